// File: rtl/vga_fill_ctrl.sv
// Rectangle fill engine sharing a framebuffer write port with a CPU store path.
// Latency: CPU stores pass through combinationally; fill writes start the cycle after an accepted start.
// Backpressure: a CPU store wins the port and stalls the fill cursor for that cycle.

package vga_fill_pkg;
    // Memory-port control word shared by the CPU store path and the framebuffer port
    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic [1:0] size;
        logic       signExt;
    } mem_ctrl_t;
endpackage

module vga_fill_ctrl
    import vga_fill_pkg::*;
#(
    parameter int WIDTH  = 80,
    parameter int HEIGHT = 120
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_cpuAddr,
    input  logic [31:0] i_cpuData,
    input  mem_ctrl_t   i_cpuCtrl,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [6:0]  i_x0,
    input  logic [6:0]  i_x1,
    input  logic [6:0]  i_y0,
    input  logic [6:0]  i_y1,
    input  logic [3:0]  i_color,
    output logic [31:0] o_pxlAddr,
    output logic [31:0] o_pxlData,
    output mem_ctrl_t   o_ctrlVGA,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bounds widened to 8 bits so the compare against a 7-bit coordinate is exact
    localparam logic [7:0] W_LIM = 8'(WIDTH);
    localparam logic [7:0] H_LIM = 8'(HEIGHT);

    state_t     state;
    state_t     state_nxt;
    logic [6:0] x0_q;
    logic [6:0] x1_q;
    logic [6:0] y0_q;
    logic [6:0] y1_q;
    logic [3:0] color_q;
    logic [6:0] cx;
    logic [6:0] cy;
    logic       err_q;

    logic       start_ok;
    logic       start_acc;
    logic       start_rej;
    logic       fill_wr;
    logic       last_px;

    // Command qualification and the per-cycle fill-write decision
    always_comb begin
        start_ok  = (i_x0 <= i_x1) && ({1'b0, i_x1} < W_LIM) &&
                    (i_y0 <= i_y1) && ({1'b0, i_y1} < H_LIM);
        start_acc = (state == IDLE) && i_start && start_ok;
        start_rej = (state == IDLE) && i_start && !start_ok;
        // A CPU store or an abort suppresses the fill write and freezes the cursor
        fill_wr   = (state == FILL) && !i_cpuCtrl.memWrite && !i_abort && !i_rst;
        last_px   = (cx == x1_q) && (cy == y1_q);
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (i_abort) begin
                    state_nxt = IDLE;
                end else if (fill_wr && last_px) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched rectangle, colour and raster cursor
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            cx      <= '0;
            cy      <= '0;
        end else if (start_acc) begin
            x0_q    <= i_x0;
            x1_q    <= i_x1;
            y0_q    <= i_y0;
            y1_q    <= i_y1;
            color_q <= i_color;
            cx      <= i_x0;
            cy      <= i_y0;
        end else if (fill_wr) begin
            // Row-major walk; the step past the final pixel is never used
            if (cx != x1_q) begin
                cx <= cx + 7'd1;
            end else begin
                cx <= x0_q;
                cy <= cy + 7'd1;
            end
        end
    end

    // Rejected start reported as a one-cycle pulse on the following cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_rej;
        end
    end

    // Write-port mux: CPU first, then the fill engine, otherwise an all-zero idle word
    always_comb begin
        o_pxlAddr = '0;
        o_pxlData = '0;
        o_ctrlVGA = '0;
        if (i_cpuCtrl.memWrite) begin
            o_pxlAddr = i_cpuAddr;
            o_pxlData = i_cpuData;
            o_ctrlVGA = i_cpuCtrl;
        end else if (fill_wr) begin
            o_pxlAddr          = {17'b0, cy, 1'b0, cx};
            o_pxlData          = {24'b0, color_q, color_q};
            o_ctrlVGA.memWrite = 1'b1;
            o_ctrlVGA.size     = 2'b00;
        end
    end

    // Status flags derived from state so reset clears them at once
    always_comb begin
        o_busy = (state == FILL) || (state == DONE);
        o_done = (state == DONE);
        o_err  = err_q;
    end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Bench for vga_fill_ctrl: table of fill commands plus hand-written stall, abort and reset sequences.
// Expected fill writes are queued when a start is driven and popped as the DUT emits them.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_vga_fill_ctrl;
    import vga_fill_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_cpuAddr;
    logic [31:0] i_cpuData;
    mem_ctrl_t   i_cpuCtrl;
    logic        i_start;
    logic        i_abort;
    logic [6:0]  i_x0, i_x1, i_y0, i_y1;
    logic [3:0]  i_color;
    logic [31:0] o_pxlAddr;
    logic [31:0] o_pxlData;
    mem_ctrl_t   o_ctrlVGA;
    logic        o_busy, o_done, o_err;

    vga_fill_ctrl #(.WIDTH(80), .HEIGHT(120)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cpuAddr (i_cpuAddr),
        .i_cpuData (i_cpuData),
        .i_cpuCtrl (i_cpuCtrl),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_x0      (i_x0),
        .i_x1      (i_x1),
        .i_y0      (i_y0),
        .i_y1      (i_y1),
        .i_color   (i_color),
        .o_pxlAddr (o_pxlAddr),
        .o_pxlData (o_pxlData),
        .o_ctrlVGA (o_ctrlVGA),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int         x0, x1, y0, y1;
        logic [3:0] color;
        bit         bad;
        int         exp_wr;
        int         exp_busy;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[7];
    int          n_chk  = 0;
    int          n_errs = 0;
    int          n_wr, n_busy, n_done, n_err;
    logic [31:0] last_addr;
    bit          no_wr;
    mem_ctrl_t   fill_ctrl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle output monitor, called at the falling edge
    task automatic mon();
        exp_t e;
        if (i_cpuCtrl.memWrite) begin
            chk("cpu_addr", o_pxlAddr, i_cpuAddr);
            chk("cpu_data", o_pxlData, i_cpuData);
            chk("cpu_ctrl", 32'(o_ctrlVGA), 32'(i_cpuCtrl));
        end else begin
            if (no_wr) chk("no_fill_write", 32'(o_ctrlVGA.memWrite), 32'd0);
            if (o_ctrlVGA.memWrite) begin
                n_wr++;
                last_addr = o_pxlAddr;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_errs++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none at %0t",
                             o_pxlAddr, o_pxlData, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("fill_addr", o_pxlAddr, e.addr);
                    chk("fill_data", o_pxlData, e.data);
                    chk("fill_ctrl", 32'(o_ctrlVGA), 32'(fill_ctrl));
                end
            end else begin
                chk("idle_addr", o_pxlAddr, 32'd0);
                chk("idle_data", o_pxlData, 32'd0);
                chk("idle_ctrl", 32'(o_ctrlVGA), 32'd0);
            end
        end
        if (o_busy) n_busy++;
        if (o_done) n_done++;
        if (o_err)  n_err++;
    endtask

    task automatic cyc();
        @(negedge i_clk);
        mon();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_fill(input vec_t v);
        exp_t e;
        for (int y = v.y0; y <= v.y1; y++) begin
            for (int x = v.x0; x <= v.x1; x++) begin
                e.addr = 32'(y * 256 + x);
                e.data = {24'h0, v.color, v.color};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_cmd(input vec_t v);
        n_wr = 0; n_busy = 0; n_done = 0; n_err = 0;
        i_x0 = 7'(v.x0); i_x1 = 7'(v.x1);
        i_y0 = 7'(v.y0); i_y1 = 7'(v.y1);
        i_color = v.color;
        if (!v.bad) push_fill(v);
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (n_done == 0 && n_err == 0 && k < 12000) begin
            cyc();
            k++;
        end
        if (k >= 12000) begin
            n_chk++;
            n_errs++;
            $display("FAIL timeout: got no done/err after %0d cycles expected one", k);
        end
        repeat (2) cyc();
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        start_cmd(v);
        wait_end();
        chk({tag, "_err"},   32'(n_err),  v.bad ? 32'd1 : 32'd0);
        chk({tag, "_done"},  32'(n_done), v.bad ? 32'd0 : 32'd1);
        chk({tag, "_writes"}, 32'(n_wr),  32'(v.exp_wr));
        chk({tag, "_busy"},  32'(n_busy), 32'(v.exp_busy));
        chk({tag, "_left"},  32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        fill_ctrl          = '0;
        fill_ctrl.memWrite = 1'b1;
        fill_ctrl.size     = 2'b00;

        //           x0  x1  y0  y1  col   bad  wr    busy
        vecs[0] = '{ 2,  4,  10, 11, 4'hA, 1'b0, 6,    7    };
        vecs[1] = '{ 5,  3,  0,  0,  4'h1, 1'b1, 0,    0    };
        vecs[2] = '{ 0,  0,  0,  120,4'h2, 1'b1, 0,    0    };
        vecs[3] = '{ 0,  80, 0,  0,  4'h3, 1'b1, 0,    0    };
        vecs[4] = '{ 79, 79, 119,119,4'h5, 1'b0, 1,    2    };
        vecs[5] = '{ 0,  79, 7,  7,  4'hF, 1'b0, 80,   81   };
        vecs[6] = '{ 0,  79, 0,  119,4'h6, 1'b0, 9600, 9601 };

        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; no_wr = 1'b0;
        i_cpuAddr = '0; i_cpuData = '0; i_cpuCtrl = '0;
        i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0; i_color = '0;
        n_wr = 0; n_busy = 0; n_done = 0; n_err = 0; last_addr = '0;

        // Reset state, and CPU passthrough while held in reset
        @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err",  32'(o_err),  32'd0);
        @(posedge i_clk); #1;
        i_cpuAddr = 32'hCAFE_0010; i_cpuData = 32'h0BAD_F00D;
        i_cpuCtrl = '0; i_cpuCtrl.memWrite = 1'b1; i_cpuCtrl.size = 2'b10;
        cyc();
        i_cpuCtrl = '0;
        i_rst = 1'b0;
        cyc();

        // Table of fill commands
        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end
        chk("full_last_addr", last_addr, 32'h0000_774F);

        // CPU stores on FILL cycles 2 and 3 stall the cursor
        start_cmd(vecs[0]);
        cyc();
        i_cpuAddr = 32'h1234_5678; i_cpuData = 32'hDEAD_BEEF;
        i_cpuCtrl = '0; i_cpuCtrl.memWrite = 1'b1; i_cpuCtrl.size = 2'b10;
        cyc();
        cyc();
        i_cpuCtrl = '0;
        wait_end();
        chk("stall_writes", 32'(n_wr),   32'd6);
        chk("stall_busy",   32'(n_busy), 32'd9);
        chk("stall_done",   32'(n_done), 32'd1);
        chk("stall_left",   32'(exp_q.size()), 32'd0);

        // Abort after three fill writes, then a fresh start is accepted
        start_cmd(vecs[0]);
        repeat (3) cyc();
        i_abort = 1'b1; no_wr = 1'b1;
        cyc();
        i_abort = 1'b0; no_wr = 1'b0;
        exp_q.delete();
        chk("abort_idle_busy", 32'(o_busy), 32'd0);
        repeat (4) cyc();
        chk("abort_writes", 32'(n_wr),   32'd3);
        chk("abort_done",   32'(n_done), 32'd0);
        run_cmd(vecs[0], "after_abort");

        // Asynchronous reset between edges in the middle of a fill
        start_cmd(vecs[0]);
        repeat (2) cyc();
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        exp_q.delete();
        repeat (2) cyc();
        i_rst = 1'b0;
        repeat (8) cyc();
        chk("midrst_writes", 32'(n_wr),   32'd2);
        chk("midrst_done_cnt", 32'(n_done), 32'd0);
        chk("midrst_busy_end", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_chk);
        $finish;
    end

endmodule
